// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants and state encodings for the FIR AXI-Lite
//               configuration block.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int unsigned ADDR_AP_CTRL  = 'h00;
    localparam int unsigned ADDR_LEN      = 'h10;
    localparam int unsigned ADDR_PERF     = 'h14;
    localparam int unsigned ADDR_TAP_BASE = 'h40;

    localparam int unsigned AP_START_BIT = 0;
    localparam int unsigned AP_DONE_BIT  = 1;
    localparam int unsigned AP_IDLE_BIT  = 2;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_RAM  = 2'd2,
        R_DATA = 2'd3
    } r_state_t;

endpackage
`default_nettype wire

// File: rtl/fir_ap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_ap_ctrl
// Description : ap_start / ap_done / ap_idle / busy flops with their priority.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_ap_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic i_start_req,
    input  logic i_core_done,
    input  logic i_done_clr,
    output logic o_ap_start,
    output logic o_ap_done,
    output logic o_ap_idle,
    output logic o_busy
);

    logic r_ap_start;
    logic r_ap_done;
    logic r_ap_idle;
    logic r_busy;

    // core_done outranks the read-clear of ap_done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ap_start <= 1'b0;
            r_ap_done  <= 1'b0;
            r_ap_idle  <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_ap_start <= 1'b0;
            if (i_core_done) begin
                r_ap_done <= 1'b1;
                r_ap_idle <= 1'b1;
                r_busy    <= 1'b0;
            end else if (i_start_req && r_ap_idle) begin
                r_ap_start <= 1'b1;
                r_ap_idle  <= 1'b0;
                r_ap_done  <= 1'b0;
                r_busy     <= 1'b1;
            end else if (i_done_clr) begin
                r_ap_done <= 1'b0;
            end
        end
    end

    assign o_ap_start = r_ap_start;
    assign o_ap_done  = r_ap_done;
    assign o_ap_idle  = r_ap_idle;
    assign o_busy     = r_busy;

endmodule
`default_nettype wire

// File: rtl/fir_axil_cfg.sv
`default_nettype none
// ============================================================================
// Module      : fir_axil_cfg
// Description : AXI-Lite config responder for the FIR: ap_ctrl, data_length,
//               tap BRAM access. Optional cycle counter via FIR_CFG_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_axil_cfg
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic [pADDR_WIDTH-1:0] core_tap_A,
    input  logic                   core_done,
    output logic                   ap_start_o,
    output logic [pDATA_WIDTH-1:0] data_length
);

    localparam logic [pADDR_WIDTH-1:0] c_ap_ctrl  = pADDR_WIDTH'(ADDR_AP_CTRL);
    localparam logic [pADDR_WIDTH-1:0] c_len      = pADDR_WIDTH'(ADDR_LEN);
    localparam logic [pADDR_WIDTH-1:0] c_tap_base = pADDR_WIDTH'(ADDR_TAP_BASE);
    localparam logic [pADDR_WIDTH-1:0] c_tap_last = pADDR_WIDTH'(ADDR_TAP_BASE + 4 * (Tape_Num - 1));

    w_state_t               r_wstate;
    r_state_t               r_rstate;
    logic [pADDR_WIDTH-1:0] r_waddr;
    logic [pADDR_WIDTH-1:0] r_raddr;
    logic                   r_awready;
    logic                   r_wready;
    logic                   r_arready;
    logic                   r_rvalid;
    logic [pDATA_WIDTH-1:0] r_rdata;
    logic [pDATA_WIDTH-1:0] r_data_length;
    logic [pDATA_WIDTH-1:0] w_reg_rdata;
    logic                   w_busy;
    logic                   w_ap_done;
    logic                   w_ap_idle;
    logic                   w_wr_commit;
    logic                   w_wr_tap;
    logic                   w_rd_tap_issue;
    logic                   w_start_req;
    logic                   w_done_clr;

    function automatic logic f_is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= c_tap_base) && (a <= c_tap_last) && (a[1:0] == 2'b00);
    endfunction

    assign w_wr_commit    = (r_wstate == W_DATA) && wvalid && r_wready;
    assign w_wr_tap       = w_wr_commit && f_is_tap(r_waddr) && !w_busy;
    assign w_rd_tap_issue = (r_rstate == R_ADDR) && f_is_tap(r_raddr) && !w_busy;
    assign w_start_req    = w_wr_commit && (r_waddr == c_ap_ctrl) && wdata[AP_START_BIT];
    assign w_done_clr     = (r_rstate == R_DATA) && r_rvalid && rready && (r_raddr == c_ap_ctrl);

    fir_ap_ctrl u_ap_ctrl (
        .clk         (axis_clk),
        .rst         (axis_rst),
        .i_start_req (w_start_req),
        .i_core_done (core_done),
        .i_done_clr  (w_done_clr),
        .o_ap_start  (ap_start_o),
        .o_ap_done   (w_ap_done),
        .o_ap_idle   (w_ap_idle),
        .o_busy      (w_busy)
    );

`ifdef FIR_CFG_PERF_EN
    localparam logic [pADDR_WIDTH-1:0] c_perf = pADDR_WIDTH'(ADDR_PERF);
    logic [31:0] r_perf_cnt;

    always_ff @(posedge axis_clk) begin
        if (axis_rst)
            r_perf_cnt <= '0;
        else if (ap_start_o)
            r_perf_cnt <= '0;
        else if (w_busy)
            r_perf_cnt <= r_perf_cnt + 32'd1;
    end
`endif

    // A pending tap write takes the BRAM port; the read waits in R_ADDR
    always_comb begin
        tap_A  = '0;
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_Di = wdata;
        if (w_busy) begin
            tap_A  = core_tap_A;
            tap_EN = 1'b1;
        end else if (w_wr_tap) begin
            tap_A  = r_waddr - c_tap_base;
            tap_EN = 1'b1;
            tap_WE = 4'hF;
        end else if (w_rd_tap_issue) begin
            tap_A  = r_raddr - c_tap_base;
            tap_EN = 1'b1;
        end
    end

    always_comb begin
        w_reg_rdata = '0;
        if (f_is_tap(r_raddr)) begin
            w_reg_rdata = '1;
        end else if (r_raddr == c_ap_ctrl) begin
            w_reg_rdata[AP_DONE_BIT] = w_ap_done;
            w_reg_rdata[AP_IDLE_BIT] = w_ap_idle;
        end else if (r_raddr == c_len) begin
            w_reg_rdata = r_data_length;
        end
`ifdef FIR_CFG_PERF_EN
        else if (r_raddr == c_perf) begin
            w_reg_rdata = pDATA_WIDTH'(r_perf_cnt);
        end
`endif
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_wstate      <= W_IDLE;
            r_awready     <= 1'b0;
            r_wready      <= 1'b0;
            r_waddr       <= '0;
            r_data_length <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (awvalid) begin
                        r_awready <= 1'b1;
                        r_waddr   <= awaddr;
                        r_wstate  <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b1;
                    r_wstate  <= W_DATA;
                end
                W_DATA: begin
                    if (w_wr_commit) begin
                        r_wready <= 1'b0;
                        r_wstate <= W_IDLE;
                        if (r_waddr == c_len && !w_busy)
                            r_data_length <= wdata;
                    end
                end
                default: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_wstate  <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_raddr   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        r_arready <= 1'b1;
                        r_raddr   <= araddr;
                        r_rstate  <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    r_arready <= 1'b0;
                    if (w_rd_tap_issue) begin
                        if (!w_wr_tap)
                            r_rstate <= R_RAM;
                    end else begin
                        r_rdata  <= w_reg_rdata;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_DATA;
                    end
                end
                R_RAM: begin
                    r_rdata  <= tap_Do;
                    r_rvalid <= 1'b1;
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    if (rready) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign awready     = r_awready;
    assign wready      = r_wready;
    assign arready     = r_arready;
    assign rvalid      = r_rvalid;
    assign rdata       = r_rdata;
    assign data_length = r_data_length;

endmodule
`default_nettype wire

// File: tb/tb_fir_axil_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_axil_cfg
// Description : Directed self-checking bench for fir_axil_cfg with a BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_axil_cfg;

    logic        axis_clk = 1'b0;
    logic        axis_rst = 1'b1;
    logic [11:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [11:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  tap_WE;
    logic        tap_EN;
    logic [31:0] tap_Di;
    logic [11:0] tap_A;
    logic [31:0] tap_Do;
    logic [11:0] core_tap_A = '0;
    logic        core_done = 1'b0;
    logic        ap_start_o;
    logic [31:0] data_length;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int start_cnt = 0;
    int wr_cnt    = 0;
    logic [11:0] last_rd_A = '0;
    logic [31:0] mem [0:15];
    int taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    fir_axil_cfg dut (
        .axis_clk    (axis_clk),
        .axis_rst    (axis_rst),
        .awaddr      (awaddr),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wvalid      (wvalid),
        .wready      (wready),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .rready      (rready),
        .tap_WE      (tap_WE),
        .tap_EN      (tap_EN),
        .tap_Di      (tap_Di),
        .tap_A       (tap_A),
        .tap_Do      (tap_Do),
        .core_tap_A  (core_tap_A),
        .core_done   (core_done),
        .ap_start_o  (ap_start_o),
        .data_length (data_length)
    );

    always #5 axis_clk = ~axis_clk;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        tap_Do = '0;
    end

    // Registered-output tap BRAM plus activity monitors
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) begin
                mem[tap_A[5:2]] <= tap_Di;
                wr_cnt <= wr_cnt + 1;
            end else begin
                last_rd_A <= tap_A;
            end
            tap_Do <= mem[tap_A[5:2]];
        end
    end

    always @(negedge axis_clk) if (ap_start_o === 1'b1) start_cnt = start_cnt + 1;

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        int n;
        @(negedge axis_clk);
        awaddr = a; awvalid = 1'b1; n = 0;
        while (awready !== 1'b1 && n < 20) begin @(negedge axis_clk); n++; end
        if (n >= 20) begin total_cnt++; $display("FAIL awready_timeout addr=%h", a); end
        @(negedge axis_clk);
        awvalid = 1'b0; wdata = d; wvalid = 1'b1; n = 0;
        while (wready !== 1'b1 && n < 20) begin @(negedge axis_clk); n++; end
        if (n >= 20) begin total_cnt++; $display("FAIL wready_timeout addr=%h", a); end
        @(negedge axis_clk);
        wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
        int n;
        @(negedge axis_clk);
        araddr = a; arvalid = 1'b1; n = 0;
        while (arready !== 1'b1 && n < 20) begin @(negedge axis_clk); n++; end
        if (n >= 20) begin total_cnt++; $display("FAIL arready_timeout addr=%h", a); end
        @(negedge axis_clk);
        arvalid = 1'b0; rready = 1'b1; n = 0;
        while (rvalid !== 1'b1 && n < 20) begin @(negedge axis_clk); n++; end
        if (n >= 20) begin total_cnt++; $display("FAIL rvalid_timeout addr=%h", a); end
        d = rdata;
        @(negedge axis_clk);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        axis_rst = 1'b1;
        repeat (3) @(negedge axis_clk);
        total_cnt++;
        if ({awready, wready, arready, rvalid} !== 4'b0000)
            $display("FAIL reset_handshake got=%b exp=0000", {awready, wready, arready, rvalid});
        else pass_cnt++;
        total_cnt++;
        if ({tap_WE, tap_EN, ap_start_o} !== 6'b0)
            $display("FAIL reset_tap_start got=%b exp=000000", {tap_WE, tap_EN, ap_start_o});
        else pass_cnt++;
        total_cnt++;
        if (rdata !== 32'd0 || data_length !== 32'd0)
            $display("FAIL reset_rdata_len got=%h/%h exp=0/0", rdata, data_length);
        else pass_cnt++;
        axis_rst = 1'b0;
        axi_read(12'h000, d);
        total_cnt++;
        if (d !== 32'h4) $display("FAIL reset_ap_ctrl got=%h exp=4", d); else pass_cnt++;
    endtask

    task automatic test_len_taps();
        logic [31:0] d;
        axi_write(12'h010, 32'd600);
        axi_read(12'h010, d);
        total_cnt++;
        if (d !== 32'd600) $display("FAIL len_read got=%0d exp=600", d); else pass_cnt++;
        total_cnt++;
        if (data_length !== 32'd600) $display("FAIL len_port got=%0d exp=600", data_length); else pass_cnt++;
        for (int k = 0; k < 11; k++) axi_write(12'(12'h040 + 4 * k), 32'(taps[k]));
        for (int k = 0; k < 11; k++) begin
            axi_read(12'(12'h040 + 4 * k), d);
            total_cnt++;
            if (d !== 32'(taps[k])) $display("FAIL tap%0d_read got=%h exp=%h", k, d, 32'(taps[k]));
            else pass_cnt++;
            total_cnt++;
            if (last_rd_A !== 12'(4 * k)) $display("FAIL tap%0d_addr got=%h exp=%h", k, last_rd_A, 12'(4 * k));
            else pass_cnt++;
        end
        axi_write(12'h024, 32'd5);
        axi_read(12'h024, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL unmapped_read got=%h exp=0", d); else pass_cnt++;
    endtask

    task automatic test_start();
        logic [31:0] d;
        int wr0;
        start_cnt = 0;
        axi_write(12'h000, 32'h1);
        repeat (3) @(negedge axis_clk);
        total_cnt++;
        if (start_cnt !== 1) $display("FAIL start_pulse_cycles got=%0d exp=1", start_cnt); else pass_cnt++;
        axi_read(12'h000, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL busy_ap_ctrl got=%h exp=0", d); else pass_cnt++;
        wr0 = wr_cnt;
        axi_write(12'h040, 32'd99);
        axi_write(12'h010, 32'd7);
        axi_write(12'h000, 32'h1);
        repeat (3) @(negedge axis_clk);
        total_cnt++;
        if (wr_cnt !== wr0) $display("FAIL busy_tap_write got=%0d exp=%0d", wr_cnt, wr0); else pass_cnt++;
        total_cnt++;
        if (data_length !== 32'd600) $display("FAIL busy_len_write got=%0d exp=600", data_length); else pass_cnt++;
        total_cnt++;
        if (start_cnt !== 1) $display("FAIL busy_restart got=%0d exp=1", start_cnt); else pass_cnt++;
    endtask

    task automatic test_busy();
        logic [31:0] d;
        @(negedge axis_clk);
        core_tap_A = 12'h020;
        @(negedge axis_clk);
        total_cnt++;
        if ({tap_A, tap_EN, tap_WE} !== {12'h020, 1'b1, 4'h0})
            $display("FAIL busy_tap_mux got=%h/%b/%h exp=020/1/0", tap_A, tap_EN, tap_WE);
        else pass_cnt++;
        core_tap_A = 12'h008;
        @(negedge axis_clk);
        total_cnt++;
        if (tap_A !== 12'h008) $display("FAIL busy_tap_follow got=%h exp=008", tap_A); else pass_cnt++;
        axi_read(12'h048, d);
        total_cnt++;
        if (d !== 32'hFFFF_FFFF) $display("FAIL busy_tap_read got=%h exp=ffffffff", d); else pass_cnt++;
        @(negedge axis_clk); core_done = 1'b1;
        @(negedge axis_clk); core_done = 1'b0;
        axi_read(12'h000, d);
        total_cnt++;
        if (d !== 32'h6) $display("FAIL done_read1 got=%h exp=6", d); else pass_cnt++;
        axi_read(12'h000, d);
        total_cnt++;
        if (d !== 32'h4) $display("FAIL done_read2 got=%h exp=4", d); else pass_cnt++;
        total_cnt++;
        if (tap_EN !== 1'b0) $display("FAIL idle_tap_en got=%b exp=0", tap_EN); else pass_cnt++;
        axi_read(12'h040, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL dropped_tap0 got=%h exp=0", d); else pass_cnt++;
    endtask

    task automatic test_rready_hold();
        int n;
        @(negedge axis_clk);
        araddr = 12'h04C; arvalid = 1'b1; n = 0;
        while (arready !== 1'b1 && n < 20) begin @(negedge axis_clk); n++; end
        @(negedge axis_clk);
        arvalid = 1'b0;
        while (rvalid !== 1'b1 && n < 40) begin @(negedge axis_clk); n++; end
        if (n >= 40) begin total_cnt++; $display("FAIL hold_timeout n=%0d", n); end
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if (rvalid !== 1'b1 || rdata !== 32'd23)
                $display("FAIL hold_cycle%0d got=%b/%h exp=1/00000017", c, rvalid, rdata);
            else pass_cnt++;
            @(negedge axis_clk);
        end
        rready = 1'b1;
        @(negedge axis_clk);
        rready = 1'b0;
        total_cnt++;
        if (rvalid !== 1'b0) $display("FAIL hold_release got=%b exp=0", rvalid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int wr0;
        int n;
        wr0 = wr_cnt;
        @(negedge axis_clk);
        awaddr = 12'h044; awvalid = 1'b1; n = 0;
        while (awready !== 1'b1 && n < 20) begin @(negedge axis_clk); n++; end
        axis_rst = 1'b1; awvalid = 1'b0;
        repeat (2) @(negedge axis_clk);
        axis_rst = 1'b0;
        wdata = 32'h1234; wvalid = 1'b1;
        repeat (3) @(negedge axis_clk);
        wvalid = 1'b0;
        total_cnt++;
        if (wr_cnt !== wr0) $display("FAIL rstmid_bram_write got=%0d exp=%0d", wr_cnt, wr0); else pass_cnt++;
        total_cnt++;
        if (data_length !== 32'd0) $display("FAIL rstmid_len got=%h exp=0", data_length); else pass_cnt++;
        axi_read(12'h044, d);
        total_cnt++;
        if (d !== 32'hFFFF_FFF6) $display("FAIL rstmid_tap1 got=%h exp=fffffff6", d); else pass_cnt++;
    endtask

    task automatic test_perf();
        logic [31:0] d;
`ifdef FIR_CFG_PERF_EN
        axi_write(12'h000, 32'h1);
        total_cnt++;
        if (ap_start_o !== 1'b1) $display("FAIL perf_start got=%b exp=1", ap_start_o); else pass_cnt++;
        repeat (120) @(negedge axis_clk);
        core_done = 1'b1;
        @(negedge axis_clk);
        core_done = 1'b0;
        repeat (4) @(negedge axis_clk);
        axi_read(12'h014, d);
        total_cnt++;
        if (d !== 32'd120) $display("FAIL perf_count got=%0d exp=120", d); else pass_cnt++;
`else
        axi_read(12'h014, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL perf_unmapped got=%h exp=0", d); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_len_taps();
        test_start();
        test_busy();
        test_rready_hold();
        test_reset_mid();
        test_perf();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
